// File: rtl/vga_timing_pkg.sv
// Timing constant sets, sync polarity encodings and small decode helpers shared by
// the VGA timing generator (the frame counter is built only under VGA_TIMING_FRAME_CNT_EN).
package vga_timing_pkg;

    localparam int VGA640_H_DISP = 640;
    localparam int VGA640_H_FP   = 16;
    localparam int VGA640_H_SYNC = 96;
    localparam int VGA640_H_BP   = 48;
    localparam int VGA640_V_DISP = 480;
    localparam int VGA640_V_FP   = 10;
    localparam int VGA640_V_SYNC = 2;
    localparam int VGA640_V_BP   = 33;

    localparam int VGA800_H_DISP = 800;
    localparam int VGA800_H_FP   = 40;
    localparam int VGA800_H_SYNC = 128;
    localparam int VGA800_H_BP   = 88;
    localparam int VGA800_V_DISP = 600;
    localparam int VGA800_V_FP   = 1;
    localparam int VGA800_V_SYNC = 4;
    localparam int VGA800_V_BP   = 23;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        logic p_tick;
        logic hsync;
        logic vsync;
        logic video_on;
        logic sof;
        logic eol;
    } vga_flags_t;

    function automatic int div_cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // True when value lies in [lo, lo+len-1]; an empty window never matches.
    function automatic logic in_window(input int value, input int lo, input int len);
        return (value >= lo) && (value < (lo + len));
    endfunction

    function automatic vga_flags_t flags_idle(input bit hs_pol, input bit vs_pol);
        vga_flags_t f;
        f.p_tick   = 1'b0;
        f.hsync    = ~hs_pol;
        f.vsync    = ~vs_pol;
        f.video_on = 1'b0;
        f.sof      = 1'b0;
        f.eol      = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/vga_timing_gen_div.sv
// Pixel-rate divider: counts 0..DIV-1 while enabled and strobes tick on the last count.
module vga_pix_div
    import vga_timing_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);
    localparam int            CW       = div_cnt_width(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r;

    assign tick = en && (cnt_r == CNT_LAST);

    // Divider count; frozen while en is low, cleared by restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else if (en) begin
            if (restart || (cnt_r == CNT_LAST)) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered, mutually aligned outputs.
// Optional frame counter built when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISP = VGA640_H_DISP,
    parameter int H_FP   = VGA640_H_FP,
    parameter int H_SYNC = VGA640_H_SYNC,
    parameter int H_BP   = VGA640_H_BP,
    parameter int V_DISP = VGA640_V_DISP,
    parameter int V_FP   = VGA640_V_FP,
    parameter int V_SYNC = VGA640_V_SYNC,
    parameter int V_BP   = VGA640_V_BP,
    parameter int DIV    = 2,
    parameter bit HS_POL = POL_ACTIVE_LOW,
    parameter bit VS_POL = POL_ACTIVE_LOW,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         restart,
    output logic         p_tick,
    output logic         hsync,
    output logic         vsync,
    output logic         video_on,
    output logic         sof,
    output logic         eol,
    output logic [W-1:0] pixel_x,
    output logic [W-1:0] pixel_y,
    output logic [15:0]  frame_cnt
);
    localparam int H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_DISP + H_FP;
    localparam int VS_START = V_DISP + V_FP;

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] H_LAST   = W'(H_TOTAL - 1);
    localparam logic [W-1:0] V_LAST   = W'(V_TOTAL - 1);

    generate
        if ((H_TOTAL > (1 << W)) || (V_TOTAL > (1 << W)) || (DIV < 1)) begin : g_bad_cfg
            $fatal(1, "vga_timing_gen: totals exceed 2**W or DIV < 1");
        end
    endgenerate

    logic         tick_s;
    logic         h_last_s;
    logic         v_last_s;
    logic [W-1:0] h_cnt_r;
    logic [W-1:0] v_cnt_r;
    vga_flags_t   flags_s;
    vga_flags_t   flags_r;
    logic [W-1:0] pixel_x_r;
    logic [W-1:0] pixel_y_r;

    vga_pix_div #(
        .DIV (DIV)
    ) u_pix_div (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .restart (restart),
        .tick    (tick_s)
    );

    // Decode of the present divider/counter state, captured by the output stage.
    always_comb begin
        h_last_s         = (h_cnt_r == H_LAST);
        v_last_s         = (v_cnt_r == V_LAST);
        flags_s.p_tick   = tick_s;
        flags_s.hsync    = in_window(int'(h_cnt_r), HS_START, H_SYNC) ? HS_POL : ~HS_POL;
        flags_s.vsync    = in_window(int'(v_cnt_r), VS_START, V_SYNC) ? VS_POL : ~VS_POL;
        flags_s.video_on = (int'(h_cnt_r) < H_DISP) && (int'(v_cnt_r) < V_DISP);
        flags_s.sof      = tick_s && (h_cnt_r == CNT_ZERO) && (v_cnt_r == CNT_ZERO);
        flags_s.eol      = tick_s && h_last_s;
    end

    // Raster position: restart beats a coincident tick, v advances only on the h wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_r <= CNT_ZERO;
            v_cnt_r <= CNT_ZERO;
        end else if (en) begin
            if (restart) begin
                h_cnt_r <= CNT_ZERO;
                v_cnt_r <= CNT_ZERO;
            end else if (tick_s) begin
                if (h_last_s) begin
                    h_cnt_r <= CNT_ZERO;
                    v_cnt_r <= v_last_s ? CNT_ZERO : (v_cnt_r + CNT_ONE);
                end else begin
                    h_cnt_r <= h_cnt_r + CNT_ONE;
                end
            end
        end
    end

    // Output stage: one clk behind the state it decodes, frozen together with en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r   <= flags_idle(HS_POL, VS_POL);
            pixel_x_r <= CNT_ZERO;
            pixel_y_r <= CNT_ZERO;
        end else if (en) begin
            flags_r   <= flags_s;
            pixel_x_r <= h_cnt_r;
            pixel_y_r <= v_cnt_r;
        end
    end

    assign p_tick   = flags_r.p_tick;
    assign hsync    = flags_r.hsync;
    assign vsync    = flags_r.vsync;
    assign video_on = flags_r.video_on;
    assign sof      = flags_r.sof;
    assign eol      = flags_r.eol;
    assign pixel_x  = pixel_x_r;
    assign pixel_y  = pixel_y_r;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Completed-frame count; a restart on the wrapping tick suppresses the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_r <= 16'd0;
        end else if (en && !restart && tick_s && h_last_s && v_last_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_r;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a linear-position raster model predicts every output cycle for a
// default 640x480 instance and a tiny active-high-sync DIV=1 instance.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        p_tick;
        logic        hsync;
        logic        vsync;
        logic        video_on;
        logic        sof;
        logic        eol;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic restart;

    logic        p_tick_a, hsync_a, vsync_a, video_on_a, sof_a, eol_a;
    logic [9:0]  pixel_x_a, pixel_y_a;
    logic [15:0] frame_cnt_a;
    logic        p_tick_b, hsync_b, vsync_b, video_on_b, sof_b, eol_b;
    logic [9:0]  pixel_x_b, pixel_y_b;
    logic [15:0] frame_cnt_b;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .reset(reset), .en(en), .restart(restart),
        .p_tick(p_tick_a), .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
        .sof(sof_a), .eol(eol_a), .pixel_x(pixel_x_a), .pixel_y(pixel_y_a),
        .frame_cnt(frame_cnt_a)
    );

    vga_timing_gen #(
        .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .W(10)
    ) dut_b (
        .clk(clk), .reset(reset), .en(en), .restart(restart),
        .p_tick(p_tick_b), .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
        .sof(sof_b), .eol(eol_b), .pixel_x(pixel_x_b), .pixel_y(pixel_y_b),
        .frame_cnt(frame_cnt_b)
    );

    obs_t act_a, act_b;
    assign act_a = {p_tick_a, hsync_a, vsync_a, video_on_a, sof_a, eol_a, pixel_x_a, pixel_y_a, frame_cnt_a};
    assign act_b = {p_tick_b, hsync_b, vsync_b, video_on_b, sof_b, eol_b, pixel_x_b, pixel_y_b, frame_cnt_b};

    int cfg_hd  [2] = '{640, 8};
    int cfg_hf  [2] = '{16, 2};
    int cfg_hs  [2] = '{96, 3};
    int cfg_hb  [2] = '{48, 2};
    int cfg_vd  [2] = '{480, 4};
    int cfg_vf  [2] = '{10, 1};
    int cfg_vs  [2] = '{2, 2};
    int cfg_vb  [2] = '{33, 1};
    int cfg_div [2] = '{2, 1};
    bit cfg_hp  [2] = '{1'b0, 1'b1};
    bit cfg_vp  [2] = '{1'b0, 1'b1};

    int   phase  [2];
    int   pos    [2];
    int   frames [2];
    obs_t held   [2];
    obs_t q_a [$];
    obs_t q_b [$];

    int checks = 0;
    int errors = 0;

    function automatic int h_total(input int m);
        return cfg_hd[m] + cfg_hf[m] + cfg_hs[m] + cfg_hb[m];
    endfunction

    function automatic int v_total(input int m);
        return cfg_vd[m] + cfg_vf[m] + cfg_vs[m] + cfg_vb[m];
    endfunction

    function automatic int fc_expect(input int n);
`ifdef VGA_TIMING_FRAME_CNT_EN
        return n % 65536;
`else
        return 0;
`endif
    endfunction

    function automatic obs_t idle_obs(input int m);
        obs_t o;
        o = '0;
        o.hsync = ~cfg_hp[m];
        o.vsync = ~cfg_vp[m];
        return o;
    endfunction

    // Reference model: advances one linear pixel position per tick and predicts the outputs.
    initial begin
        obs_t e;
        int ht, vt, x, y, hs0, vs0;
        bit tk;
        forever begin
            @(posedge clk);
            for (int m = 0; m < 2; m++) begin
                if (reset) begin
                    phase[m]  = 0;
                    pos[m]    = 0;
                    frames[m] = 0;
                    held[m]   = idle_obs(m);
                end else if (en) begin
                    ht  = h_total(m);
                    vt  = v_total(m);
                    x   = pos[m] % ht;
                    y   = pos[m] / ht;
                    hs0 = cfg_hd[m] + cfg_hf[m];
                    vs0 = cfg_vd[m] + cfg_vf[m];
                    tk  = (phase[m] == cfg_div[m] - 1);
                    e.x        = 10'(x);
                    e.y        = 10'(y);
                    e.p_tick   = tk;
                    e.hsync    = ((x >= hs0) && (x < hs0 + cfg_hs[m])) ? cfg_hp[m] : ~cfg_hp[m];
                    e.vsync    = ((y >= vs0) && (y < vs0 + cfg_vs[m])) ? cfg_vp[m] : ~cfg_vp[m];
                    e.video_on = (x < cfg_hd[m]) && (y < cfg_vd[m]);
                    e.sof      = tk && (pos[m] == 0);
                    e.eol      = tk && (x == ht - 1);
                    if (restart) begin
                        phase[m] = 0;
                        pos[m]   = 0;
                    end else if (tk) begin
                        phase[m] = 0;
                        pos[m]   = pos[m] + 1;
                        if (pos[m] == ht * vt) begin
                            pos[m]    = 0;
                            frames[m] = (frames[m] + 1) % 65536;
                        end
                    end else begin
                        phase[m] = phase[m] + 1;
                    end
                    e.fc    = 16'(fc_expect(frames[m]));
                    held[m] = e;
                end
                if (m == 0) q_a.push_back(held[m]);
                else        q_b.push_back(held[m]);
            end
        end
    end

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got pt=%b hs=%b vs=%b vid=%b sof=%b eol=%b x=%0d y=%0d fc=%0d, want pt=%b hs=%b vs=%b vid=%b sof=%b eol=%b x=%0d y=%0d fc=%0d",
                     name, $time, act.p_tick, act.hsync, act.vsync, act.video_on, act.sof, act.eol,
                     act.x, act.y, act.fc, exp.p_tick, exp.hsync, exp.vsync, exp.video_on,
                     exp.sof, exp.eol, exp.x, exp.y, exp.fc);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    // Monitor: every falling edge, pop the prediction for the last rising edge and compare.
    initial begin
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) check_obs("dut_a", act_a, q_a.pop_front());
            if (q_b.size() > 0) check_obs("dut_b", act_b, q_b.pop_front());
        end
    end

    // Bounded wait (on falling edges) for model m to reach column tx, row ty (ty<0: any row).
    task automatic wait_pos(input int m, input int tx, input int ty, input int minf,
                            input int budget, input string name);
        int k;
        k = 0;
        while (!(((pos[m] % h_total(m)) == tx) && ((ty < 0) || ((pos[m] / h_total(m)) == ty))
                 && (frames[m] >= minf)) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d clks, got pos %0d, want column %0d", name, k, pos[m], tx);
        end
    endtask

    initial begin
        int fc_before;
        reset   = 1'b1;
        en      = 1'b0;
        restart = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;

        // Mid-frame asynchronous reset after three completed frames of the small instance.
        wait_pos(1, 5, 2, 3, 2000, "wait_three_frames");
        check_val("fc_before_reset", frame_cnt_b, fc_expect(3));
        #1 reset = 1'b1;
        #1;
        check_val("async_fc_b", frame_cnt_b, 0);
        check_val("async_hs_b", hsync_b, 0);
        check_val("async_vs_b", vsync_b, 0);
        check_val("async_vid_b", video_on_b, 0);
        check_val("async_x_b", pixel_x_b, 0);
        check_val("async_hs_a", hsync_a, 1);
        check_val("async_vs_a", vsync_a, 1);
        check_val("async_vid_a", video_on_a, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Free run across the first line's sync window of the default instance.
        repeat (1700) @(negedge clk);

        // Freeze mid-line at column 300 for 50 clks.
        wait_pos(0, 300, -1, 0, 2000, "wait_col_300");
        en = 1'b0;
        repeat (50) @(negedge clk);
        en = 1'b1;
        repeat (100) @(negedge clk);

        // Restart coincident with the tick on the last pixel of the small frame.
        wait_pos(1, 14, 7, 0, 500, "wait_last_pixel");
        fc_before = frames[1];
        restart   = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        check_val("restart_x", pixel_x_b, 0);
        check_val("restart_y", pixel_y_b, 0);
        check_val("restart_fc", frame_cnt_b, fc_expect(fc_before));

        // Randomised enable and restart traffic.
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            en      = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 299) == 0);
        end
        en      = 1'b1;
        restart = 1'b0;
        repeat (300) @(negedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
